// File: rtl/pipe_hazard_if.sv
// Bundle between the ID stage and the hazard/forwarding unit.
// master = core side (drives ID info and stage results), slave = hazard unit.
interface pipe_hazard_if #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [AW-1:0]    id_rs1, id_rs2;
  logic             id_rs1_used, id_rs2_used;
  logic [AW-1:0]    id_rd;
  logic             id_rf_we;
  logic             id_is_load;
  logic             ex_redirect;
  logic             mem_busy;
  logic [DW-1:0]    ex_res, mem_res, wb_res;
  logic [DW-1:0]    rf_rD1, rf_rD2;
  logic [DW-1:0]    fwd_rD1, fwd_rD2;
  logic [1:0]       fwd_sel1, fwd_sel2;
  logic             stall_if, stall_id, flush_id, bubble_ex, freeze;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rf_we, id_is_load, ex_redirect, mem_busy,
           ex_res, mem_res, wb_res, rf_rD1, rf_rD2,
    output fwd_rD1, fwd_rD2, fwd_sel1, fwd_sel2,
           stall_if, stall_id, flush_id, bubble_ex, freeze,
           stall_cnt, flush_cnt
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rf_we, id_is_load, ex_redirect, mem_busy,
           ex_res, mem_res, wb_res, rf_rD1, rf_rD2,
    input  fwd_rD1, fwd_rD2, fwd_sel1, fwd_sel2,
           stall_if, stall_id, flush_id, bubble_ex, freeze,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand forwarding for the 5-stage core.
// Tracks destination registers of EX/MEM/WB in a private scoreboard and
// derives bypass selects, load-use stalls, redirect flushes and bus freezes.
module pipe_hazard_unit #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int LOAD_IN_WB = 0,
  parameter int WB_BYPASS  = 1,
  parameter int CNT_W      = 32
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  pipe_hazard_if.slave hz
);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          we;
    logic          ld;
  } slot_t;

  typedef struct packed {
    logic [1:0] sel;
    logic       haz;
  } opnd_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  slot_t            r_ex, r_mem, r_wb;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  opnd_t w_op1, w_op2;
  logic  w_load_use, w_stall_applied;
  logic  w_stall_if, w_stall_id, w_flush_id, w_bubble_ex, w_freeze;

  // x0 is hardwired zero, so it never matches a producer
  function automatic logic hit(slot_t s, logic [AW-1:0] rs, logic used);
    return s.v && s.we && (s.rd == rs) && (rs != '0) && used;
  endfunction

  // Youngest matching producer wins; a load whose data is not out yet stalls
  function automatic opnd_t resolve(slot_t ex, slot_t mem, slot_t wb,
                                    logic [AW-1:0] rs, logic used);
    opnd_t r;
    r = '0;
    if (hit(ex, rs, used)) begin
      if (ex.ld) r.haz = 1'b1;
      else       r.sel = 2'd1;
    end else if (hit(mem, rs, used)) begin
      if (mem.ld && (LOAD_IN_WB != 0)) r.haz = 1'b1;
      else                             r.sel = 2'd2;
    end else if ((WB_BYPASS != 0) && hit(wb, rs, used)) begin
      r.sel = 2'd3;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pick(logic [1:0] sel, logic [DW-1:0] rf,
                                         logic [DW-1:0] ex, logic [DW-1:0] mem,
                                         logic [DW-1:0] wb);
    case (sel)
      2'd1:    return ex;
      2'd2:    return mem;
      2'd3:    return wb;
      default: return rf;
    endcase
  endfunction

  // Per-operand producer lookup against the scoreboard
  always_comb begin
    w_op1 = resolve(r_ex, r_mem, r_wb, hz.id_rs1, hz.id_rs1_used);
    w_op2 = resolve(r_ex, r_mem, r_wb, hz.id_rs2, hz.id_rs2_used);
  end

  // Pipe control: freeze beats redirect, redirect beats load-use stall
  always_comb begin
    w_freeze    = hz.mem_busy;
    w_load_use  = w_op1.haz | w_op2.haz;
    w_stall_if  = 1'b0;
    w_stall_id  = 1'b0;
    w_flush_id  = 1'b0;
    w_bubble_ex = 1'b0;
    if (w_freeze) begin
      w_stall_if = 1'b1;
      w_stall_id = 1'b1;
    end else if (hz.ex_redirect) begin
      // ID instruction is wrong-path, so its hazard no longer matters
      w_flush_id  = 1'b1;
      w_bubble_ex = 1'b1;
    end else if (w_load_use) begin
      w_stall_if  = 1'b1;
      w_stall_id  = 1'b1;
      w_bubble_ex = 1'b1;
    end
    w_stall_applied = w_load_use & ~w_freeze & ~hz.ex_redirect;
  end

  // Scoreboard shift; a held bus freezes every slot including EX
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!w_freeze) begin
      r_wb     <= r_mem;
      r_mem    <= r_ex;
      r_ex.v   <= hz.id_valid & ~w_bubble_ex;
      r_ex.rd  <= hz.id_rd;
      r_ex.we  <= hz.id_rf_we;
      r_ex.ld  <= hz.id_is_load;
    end
  end

  // Saturating performance counters
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_applied && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush_id && (r_flush_cnt != '1))      r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign hz.fwd_sel1  = w_op1.sel;
  assign hz.fwd_sel2  = w_op2.sel;
  assign hz.fwd_rD1   = pick(w_op1.sel, hz.rf_rD1, hz.ex_res, hz.mem_res, hz.wb_res);
  assign hz.fwd_rD2   = pick(w_op2.sel, hz.rf_rD2, hz.ex_res, hz.mem_res, hz.wb_res);
  assign hz.stall_if  = w_stall_if;
  assign hz.stall_id  = w_stall_id;
  assign hz.flush_id  = w_flush_id;
  assign hz.bubble_ex = w_bubble_ex;
  assign hz.freeze    = w_freeze;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule
